// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment vector type,
// segment patterns for the BCD digits, the dash shown for non-BCD codes,
// and the scan FSM state encoding.
package seg7_pkg;

    // {a,b,c,d,e,f,g}, active-high
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_0    = 7'b1111110;
    localparam seg7_t SEG7_1    = 7'b0110000;
    localparam seg7_t SEG7_2    = 7'b1101101;
    localparam seg7_t SEG7_3    = 7'b1111001;
    localparam seg7_t SEG7_4    = 7'b0110011;
    localparam seg7_t SEG7_5    = 7'b1011011;
    localparam seg7_t SEG7_6    = 7'b1011111;
    localparam seg7_t SEG7_7    = 7'b1110000;
    localparam seg7_t SEG7_8    = 7'b1111111;
    localparam seg7_t SEG7_9    = 7'b1111011;
    localparam seg7_t SEG7_DASH = 7'b0000001;
    localparam seg7_t SEG7_OFF  = 7'b0000000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD digit to segment decoder. Codes 10..15 show a dash, so
// the output is always a defined pattern.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output seg7_t      seg
);

    // Table lookup with the dash as the fall-through value
    always_comb begin
        seg = SEG7_DASH;
        case (digit)
            4'd0:    seg = SEG7_0;
            4'd1:    seg = SEG7_1;
            4'd2:    seg = SEG7_2;
            4'd3:    seg = SEG7_3;
            4'd4:    seg = SEG7_4;
            4'd5:    seg = SEG7_5;
            4'd6:    seg = SEG7_6;
            4'd7:    seg = SEG7_7;
            4'd8:    seg = SEG7_8;
            4'd9:    seg = SEG7_9;
            default: seg = SEG7_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// A new value is accepted into a shadow register through a load/ready
// handshake and copied to the displayed register only at a frame boundary
// (or immediately while idle), so a frame never mixes old and new digits.
// Outputs are registered and computed from the next-cycle scan position, so
// they always line up with the current idx/cnt.
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 1000,
    parameter int GUARD    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    output logic                  ld_ready,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   dig_en
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    scan_state_t               state_reg, state_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [4*N_DIGITS-1:0]     shadow_reg, shadow_next;
    logic [4*N_DIGITS-1:0]     disp_reg, disp_next;
    logic                      pending_reg, pending_next;
    seg7_t                     seg_reg, seg_next;
    logic [N_DIGITS-1:0]       dig_en_reg, dig_en_next;

    logic                      frame_wrap;
    logic                      accept;
    logic                      commit;
    logic                      lit;
    logic                      lz_blank;
    logic [3:0]                digit_arr [N_DIGITS];
    logic [3:0]                cur_digit;
    seg7_t                     dec_seg;

    // Scan FSM and position counters: IDLE holds idx/cnt at zero, SCAN walks
    // cnt through each slot and steps idx at the end of every slot
    always_comb begin
        state_next = en ? ST_SCAN : ST_IDLE;
        idx_next   = '0;
        cnt_next   = '0;
        frame_wrap = 1'b0;
        if (state_reg == ST_SCAN && en) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
                if (idx_reg == IDX_LAST) begin
                    idx_next   = '0;
                    frame_wrap = 1'b1;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
                idx_next = idx_reg;
            end
        end
    end

    // Load handshake and commit: a pending value is never accepted and
    // committed on the same edge, so a load coinciding with a frame wrap
    // waits for the following wrap
    always_comb begin
        accept       = load && !pending_reg;
        commit       = pending_reg && ((state_reg == ST_IDLE) || frame_wrap);
        disp_next    = commit ? shadow_reg : disp_reg;
        shadow_next  = accept ? value : shadow_reg;
        pending_next = accept || (pending_reg && !commit);
    end

    // Split the next displayed value into per-digit nibbles for the mux
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digits
            assign digit_arr[gi] = disp_next[4*gi +: 4];
        end
    endgenerate

    assign cur_digit = digit_arr[idx_next];

`ifdef SEG7_LZ_BLANK_EN
    // upper_zero[i] is set when digit i and every more-significant digit are 0
    logic [N_DIGITS:0] upper_zero;
    assign upper_zero[N_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
            assign upper_zero[gi] = (digit_arr[gi] == 4'd0) && upper_zero[gi+1];
        end
    endgenerate
    assign lz_blank = (idx_next != '0) && upper_zero[idx_next];
`else
    assign lz_blank = 1'b0;
`endif

    seg7_digit_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Output pattern for the next cycle: dark while idle or in the guard
    // window at the start of each slot, otherwise the active digit
    always_comb begin
        lit         = (state_next == ST_SCAN) && (cnt_next >= CNT_GUARD);
        seg_next    = SEG7_OFF;
        dig_en_next = '0;
        if (lit) begin
            dig_en_next = N_DIGITS'(1) << idx_next;
            seg_next    = lz_blank ? SEG7_OFF : dec_seg;
        end
    end

    // State, data and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            shadow_reg  <= '0;
            disp_reg    <= '0;
            pending_reg <= 1'b0;
            seg_reg     <= SEG7_OFF;
            dig_en_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            shadow_reg  <= shadow_next;
            disp_reg    <= disp_next;
            pending_reg <= pending_next;
            seg_reg     <= seg_next;
            dig_en_reg  <= dig_en_next;
        end
    end

    assign ld_ready = !pending_reg;
    assign seg      = seg_reg;
    assign dig_en   = dig_en_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (N_DIGITS=4, DIV=4, GUARD=1).
// A reference model tracks the display as elapsed scan time plus
// shadow/disp/pending words; directed vectors, corner-case sequences and a
// randomized run are all compared against it every cycle.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int GUARD = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic        ld_ready;
    logic [6:0]  seg;
    logic [3:0]  dig_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.N_DIGITS(N), .DIV(DIV), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .value    (value),
        .ld_ready (ld_ready),
        .seg      (seg),
        .dig_en   (dig_en)
    );

    // Segment patterns for codes 0..15
    logic [6:0] pat [16];

    // Reference model state
    bit          m_scan;
    bit          m_pend;
    int          m_t;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;

    typedef struct {
        bit          rst;
        bit          en;
        bit          load;
        logic [15:0] value;
        logic [6:0]  seg;
        logic [3:0]  dig;
        bit          rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx();
        return (m_t / DIV) % N;
    endfunction

    function automatic bit m_lit();
        return m_scan && ((m_t % DIV) >= GUARD);
    endfunction

    function automatic logic [6:0] m_seg();
        logic [15:0] upper;
        if (!m_lit()) return 7'b0;
        upper = m_disp >> (4 * m_idx());
`ifdef SEG7_LZ_BLANK_EN
        if (m_idx() > 0 && upper == 16'd0) return 7'b0;
`endif
        return pat[upper[3:0]];
    endfunction

    function automatic logic [3:0] m_dig();
        if (!m_lit()) return 4'b0;
        return 4'(1 << m_idx());
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_step();
        bit wrap;
        bit commit;
        bit accept;
        if (rst) begin
            m_scan = 0; m_t = 0; m_pend = 0; m_shadow = '0; m_disp = '0;
            return;
        end
        wrap   = m_scan && en && ((m_t % (N * DIV)) == N * DIV - 1);
        commit = m_pend && (!m_scan || wrap);
        accept = load && !m_pend;
        if (commit) begin m_disp = m_shadow; m_pend = 0; end
        if (accept) begin m_shadow = value; m_pend = 1; end
        if (en) begin
            m_t    = m_scan ? m_t + 1 : 0;
            m_scan = 1;
        end else begin
            m_scan = 0;
            m_t    = 0;
        end
    endtask

    // One clock: step the model, then compare all outputs after the edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_seg",      32'(seg),      32'(m_seg()));
        chk("model_dig_en",   32'(dig_en),   32'(m_dig()));
        chk("model_ld_ready", 32'(ld_ready), 32'(!m_pend));
    endtask

    // Clock until dig_en equals target, with a bounded budget
    task automatic wait_dig(input logic [3:0] target, input string name);
        bit hit;
        hit = 0;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (dig_en === target) begin hit = 1; break; end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: dig_en %b never reached %b", name, dig_en, target);
        end
    endtask

    function automatic vec_t mk(bit r, bit e, bit l, logic [15:0] v,
                                logic [6:0] s, logic [3:0] d, bit y);
        vec_t x;
        x.rst = r; x.en = e; x.load = l; x.value = v;
        x.seg = s; x.dig = d; x.rdy = y;
        return x;
    endfunction

    initial begin
        logic [6:0] lit1234 [4];
        vec_t v;
        int slot;

        pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101;
        pat[3]  = 7'b1111001; pat[4]  = 7'b0110011; pat[5]  = 7'b1011011;
        pat[6]  = 7'b1011111; pat[7]  = 7'b1110000; pat[8]  = 7'b1111111;
        pat[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) pat[i] = 7'b0000001;

        // Expected lit patterns for 16'h1234: digit0=4, digit1=3, digit2=2, digit3=1
        lit1234[0] = 7'b0110011;
        lit1234[1] = 7'b1111001;
        lit1234[2] = 7'b1101101;
        lit1234[3] = 7'b0110000;

        // Directed vectors: reset, 10 idle cycles, load in IDLE, then scan
        vecs.push_back(mk(1, 0, 0, 16'h0000, 7'b0, 4'b0, 1));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 0, 16'h0000, 7'b0, 4'b0, 1));
        vecs.push_back(mk(0, 0, 1, 16'h1234, 7'b0, 4'b0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 7'b0, 4'b0, 1));
        for (int k = 0; k < 20; k++) begin
            slot = (k / DIV) % N;
            if (k % DIV < GUARD)
                vecs.push_back(mk(0, 1, 0, 16'h0000, 7'b0, 4'b0, 1));
            else
                vecs.push_back(mk(0, 1, 0, 16'h0000, lit1234[slot], 4'(1 << slot), 1));
        end

        rst = 1; en = 0; load = 0; value = '0;
        m_scan = 0; m_pend = 0; m_t = 0; m_shadow = '0; m_disp = '0;

        foreach (vecs[i]) begin
            v = vecs[i];
            rst = v.rst; en = v.en; load = v.load; value = v.value;
            cycle();
            chk("vec_seg",      32'(seg),      32'(v.seg));
            chk("vec_dig_en",   32'(dig_en),   32'(v.dig));
            chk("vec_ld_ready", 32'(ld_ready), 32'(v.rdy));
        end
        rst = 0; load = 0; en = 1;

        // Mid-frame load at idx=1: old frame finishes, new value from next frame
        for (int n = 0; n < 40 && !(m_idx() == 1 && (m_t % DIV) == 1); n++) cycle();
        load = 1; value = 16'h5678;
        cycle();
        chk("midload_ready_low", 32'(ld_ready), 32'(0));
        value = 16'h9999;   // ignored: ld_ready is low
        cycle();
        load = 0;
        wait_dig(4'b0100, "wait_old_d2");
        chk("old_d2_seg", 32'(seg), 32'(7'b1101101));
        chk("ready_held", 32'(ld_ready), 32'(0));
        wait_dig(4'b1000, "wait_old_d3");
        chk("old_d3_seg", 32'(seg), 32'(7'b0110000));
        wait_dig(4'b0001, "wait_new_d0");
        chk("new_d0_seg", 32'(seg), 32'(7'b1111111));
        chk("ready_back", 32'(ld_ready), 32'(1));
        wait_dig(4'b1000, "wait_new_d3");
        chk("new_d3_seg", 32'(seg), 32'(7'b1011011));

        // Non-BCD digits decode as a dash
        load = 1; value = 16'h00AF;
        cycle();
        load = 0;
        wait_dig(4'b0001, "wait_af_d0");
        chk("af_d0_dash", 32'(seg), 32'(7'b0000001));
        wait_dig(4'b0010, "wait_af_d1");
        chk("af_d1_dash", 32'(seg), 32'(7'b0000001));
        wait_dig(4'b0100, "wait_af_d2");
`ifdef SEG7_LZ_BLANK_EN
        chk("af_d2_lz", 32'(seg), 32'(7'b0));
`else
        chk("af_d2_zero", 32'(seg), 32'(7'b1111110));
`endif
        load = 1; value = 16'h0007;
        cycle();
        load = 0;
        wait_dig(4'b0001, "wait_07_d0");
        chk("v07_d0", 32'(seg), 32'(7'b1110000));
        wait_dig(4'b0010, "wait_07_d1");
`ifdef SEG7_LZ_BLANK_EN
        chk("v07_d1_lz", 32'(seg), 32'(7'b0));
`else
        chk("v07_d1_zero", 32'(seg), 32'(7'b1111110));
`endif

        // Reset mid-frame with a pending value; an accept in the reset cycle is lost
        load = 1; value = 16'h4321;
        cycle();
        chk("pre_rst_pending", 32'(ld_ready), 32'(0));
        rst = 1; value = 16'hFFFF;
        cycle();
        rst = 0; load = 0;
        chk("rst_seg", 32'(seg), 32'(0));
        chk("rst_dig_en", 32'(dig_en), 32'(0));
        chk("rst_ready", 32'(ld_ready), 32'(1));
        cycle();
        chk("rst_first_blank", 32'(dig_en), 32'(0));
        cycle();
        chk("rst_d0_en", 32'(dig_en), 32'(4'b0001));
        chk("rst_disp_zero", 32'(seg), 32'(7'b1111110));

        // Drop en during digit 2, then restart from idx 0 with a blank cycle
        wait_dig(4'b0100, "wait_drop_d2");
        en = 0;
        cycle();
        chk("drop_dig_en", 32'(dig_en), 32'(0));
        chk("drop_seg", 32'(seg), 32'(0));
        cycle();
        en = 1;
        cycle();
        chk("restart_blank", 32'(dig_en), 32'(0));
        cycle();
        chk("restart_d0", 32'(dig_en), 32'(4'b0001));

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 19) != 0);
            load  = ($urandom_range(0, 3) == 0);
            value = 16'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
